// File: rtl/sum_latch_uart_pkg.sv
// Shared types and constants for the sum-latch UART transmitter.
// SUMLATCH_UART_PARITY_EN adds an even-parity bit to every frame.
package sum_latch_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned frame_bits();
`ifdef SUMLATCH_UART_PARITY_EN
    return DATA_BITS + 3;
`else
    return DATA_BITS + 2;
`endif
  endfunction

endpackage

// File: rtl/sum_latch_uart_tx_if.sv
// Operand bus and transmitter status of the sum-latch UART core.
interface sum_latch_uart_tx_if #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned NUM_OPS = 2
);
  localparam int unsigned SUM_W = DATA_W + $clog2(NUM_OPS);

  logic [NUM_OPS-1:0] save_n;
  logic [DATA_W-1:0]  data_input;
  logic               uart_txd;
  logic               uart_tx_busy;
  logic [SUM_W-1:0]   sum_out;
  logic [NUM_OPS-1:0] op_valid;

  modport master (
    output save_n, data_input,
    input  uart_txd, uart_tx_busy, sum_out, op_valid
  );

  modport slave (
    input  save_n, data_input,
    output uart_txd, uart_tx_busy, sum_out, op_valid
  );
endinterface

// File: rtl/sum_latch_uart_byte_tx.sv
// Byte serialiser: START, 8 data bits LSB first, optional even parity
// (SUMLATCH_UART_PARITY_EN), STOP; each bit lasts CLK_DIV clocks.
module sum_latch_uart_byte_tx
  import sum_latch_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  output logic       done_o,
  output logic       txd_o,
  output logic       busy_o
);
  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       byte_q, byte_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             tick;

  assign tick   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign txd_o  = txd_q;
  assign busy_o = busy_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      txd_q   <= STOP_BIT;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // txd_d carries the level of the state being entered, so the line is registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (load_i) begin
          state_d = START;
          byte_d  = byte_i;
          txd_d   = START_BIT;
          busy_d  = 1'b1;
        end
      end
      START: if (tick) begin
        cnt_d   = '0;
        state_d = DATA;
        bit_d   = '0;
        txd_d   = byte_q[0];
      end
      DATA: if (tick) begin
        cnt_d = '0;
        if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef SUMLATCH_UART_PARITY_EN
          state_d = PARITY;
          txd_d   = ^byte_q;
`else
          state_d = STOP;
          txd_d   = STOP_BIT;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
          txd_d = byte_q[bit_q + 3'd1];
        end
      end
      PARITY: if (tick) begin
        cnt_d   = '0;
        state_d = STOP;
        txd_d   = STOP_BIT;
      end
      STOP: if (tick) begin
        cnt_d  = '0;
        done_o = 1'b1;
        if (load_i) begin
          state_d = START;
          byte_d  = byte_i;
          txd_d   = START_BIT;
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sum_latch_uart_tx.sv
// Operand latch / adder / UART transmitter: captures NUM_OPS operands on save_n
// falling edges, then sends their sum LSB byte first. Parity: SUMLATCH_UART_PARITY_EN.
module sum_latch_uart_tx
  import sum_latch_uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned NUM_OPS = 2,
  parameter int unsigned CLK_DIV = 16
) (
  input logic               clk,
  input logic               reset_n,
  sum_latch_uart_tx_if.slave bus
);
  localparam int unsigned SUM_W  = DATA_W + $clog2(NUM_OPS);
  localparam int unsigned NBYTES = (SUM_W + 7) / 8;

  logic [NUM_OPS-1:0] save_s1_q, save_s2_q, save_s3_q, fall;
  logic [DATA_W-1:0]  data_s1_q, data_s2_q;
  logic [DATA_W-1:0]  op_q [NUM_OPS];
  logic [NUM_OPS-1:0] op_valid_q, op_valid_d;
  logic [SUM_W-1:0]   sum_out_q, sum_d;
  logic               more_q, more_d;
  logic               launch, load, done, busy, txd;
  logic [7:0]         load_byte;

  assign fall = save_s3_q & ~save_s2_q;

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < NUM_OPS; i++) sum_d = sum_d + SUM_W'(op_q[i]);
  end

  // A new sum may start from IDLE or exactly as the final STOP of the previous sum ends.
  assign launch     = (&op_valid_q) && (!busy || (done && !more_q));
  assign load       = launch || (done && more_q);
  assign load_byte  = launch ? 8'(sum_d) : 8'(16'(sum_out_q) >> 8);
  assign op_valid_d = (launch ? '0 : op_valid_q) | fall;

  always_comb begin
    more_d = more_q;
    if (launch)              more_d = (NBYTES > 1);
    else if (done && more_q) more_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      save_s1_q  <= '1;
      save_s2_q  <= '1;
      save_s3_q  <= '1;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      op_valid_q <= '0;
      sum_out_q  <= '0;
      more_q     <= 1'b0;
    end else begin
      save_s1_q  <= bus.save_n;
      save_s2_q  <= save_s1_q;
      save_s3_q  <= save_s2_q;
      data_s1_q  <= bus.data_input;
      data_s2_q  <= data_s1_q;
      for (int unsigned i = 0; i < NUM_OPS; i++)
        if (fall[i]) op_q[i] <= data_s2_q;
      op_valid_q <= op_valid_d;
      if (launch) sum_out_q <= sum_d;
      more_q     <= more_d;
    end
  end

  sum_latch_uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .byte_i  (load_byte),
    .done_o  (done),
    .txd_o   (txd),
    .busy_o  (busy)
  );

  assign bus.uart_txd     = txd;
  assign bus.uart_tx_busy = busy;
  assign bus.sum_out      = sum_out_q;
  assign bus.op_valid     = op_valid_q;

endmodule

// File: tb/tb_sum_latch_uart_tx.sv
// Bench for sum_latch_uart_tx: two instances (4-bit x 2 ops, 12-bit x 8 ops) with a
// UART line decoder checked against a queue of expected bytes from an operand model.
module tb_sum_latch_uart_tx;
  localparam int CDIV = 4;
`ifdef SUMLATCH_UART_PARITY_EN
  localparam int          FB        = 11;
  localparam int          FRAME_CLK = 44;
  localparam logic [10:0] PAT0F     = 11'b10000011110;
`else
  localparam int          FB        = 10;
  localparam int          FRAME_CLK = 40;
  localparam logic [10:0] PAT0F     = 11'b01000011110;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_latch_uart_tx_if #(.DATA_W(4),  .NUM_OPS(2)) bus_a ();
  sum_latch_uart_tx_if #(.DATA_W(12), .NUM_OPS(8)) bus_b ();

  sum_latch_uart_tx #(.DATA_W(4), .NUM_OPS(2), .CLK_DIV(CDIV)) dut_a (
    .clk(clk), .reset_n(rst_n), .bus(bus_a.slave));
  sum_latch_uart_tx #(.DATA_W(12), .NUM_OPS(8), .CLK_DIV(CDIV)) dut_b (
    .clk(clk), .reset_n(rst_n), .bus(bus_b.slave));

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  exp_a [$];
  logic [7:0]  exp_b [$];
  logic [11:0] mval [2][8];
  logic [7:0]  mvalid [2];
  logic        last_par [2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
  endtask

  function automatic logic txd_of(input int id);
    return (id != 0) ? bus_b.uart_txd : bus_a.uart_txd;
  endfunction

  function automatic logic busy_of(input int id);
    return (id != 0) ? bus_b.uart_tx_busy : bus_a.uart_tx_busy;
  endfunction

  // Operand model: once every slot holds a value, the sum's bytes are expected on the line.
  task automatic model_commit(input int id, input logic [7:0] mask, input logic [11:0] val);
    int n;
    logic [7:0] all;
    logic [31:0] s;
    n   = (id != 0) ? 8 : 2;
    all = (id != 0) ? 8'hFF : 8'h03;
    for (int i = 0; i < n; i++)
      if (mask[i]) begin
        mval[id][i]   = val;
        mvalid[id][i] = 1'b1;
      end
    if (mvalid[id] == all) begin
      s = 0;
      for (int i = 0; i < n; i++) s = s + 32'(mval[id][i]);
      mvalid[id] = '0;
      if (id == 0) exp_a.push_back(s[7:0]);
      else begin
        exp_b.push_back(s[7:0]);
        exp_b.push_back(s[15:8]);
      end
    end
  endtask

  task automatic save(input int id, input logic [7:0] mask, input logic [11:0] val, input int hold);
    @(posedge clk); #1;
    if (id == 0) begin
      bus_a.data_input = val[3:0];
      bus_a.save_n     = bus_a.save_n & ~mask[1:0];
    end else begin
      bus_b.data_input = val;
      bus_b.save_n     = bus_b.save_n & ~mask;
    end
    model_commit(id, mask, val);
    repeat (hold) @(posedge clk);
    #1;
    if (id == 0) bus_a.save_n = bus_a.save_n | mask[1:0];
    else         bus_b.save_n = bus_b.save_n | mask;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int id, input logic val, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy_of(id) === val) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic busy_run(input int id, output int run);
    run = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy_of(id) !== 1'b1) break;
      run++;
      @(negedge clk);
    end
  endtask

  // Line decoder: every bit must hold CLK_DIV cycles; busy must cover frames exactly.
  task automatic rx_run(input int id);
    logic [10:0] bits;
    logic [7:0]  b8;
    logic [31:0] e;
    logic        v;
    bit          ab;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (id == 0) exp_a.delete();
        else         exp_b.delete();
      end else if (txd_of(id) !== 1'b1) begin
        ab = 1'b0;
        bits = '0;
        for (int b = 0; b < FB && !ab; b++) begin
          if (b > 0) begin
            @(negedge clk);
            if (!rst_n) begin
              ab = 1'b1;
              break;
            end
          end
          v = txd_of(id);
          bits[b] = v;
          check($sformatf("rx%0d_busy_in_frame", id), 32'(busy_of(id)), 1);
          for (int c = 1; c < CDIV; c++) begin
            @(negedge clk);
            if (!rst_n) begin
              ab = 1'b1;
              break;
            end
            check($sformatf("rx%0d_bit%0d_stable", id, b), 32'(txd_of(id)), 32'(v));
          end
        end
        if (ab) begin
          if (id == 0) exp_a.delete();
          else         exp_b.delete();
        end else begin
          b8 = bits[8:1];
          check($sformatf("rx%0d_start_bit", id), 32'(bits[0]), 0);
          check($sformatf("rx%0d_stop_bit", id), 32'(bits[FB-1]), 1);
`ifdef SUMLATCH_UART_PARITY_EN
          check($sformatf("rx%0d_parity", id), 32'(bits[9]), 32'(^b8));
          last_par[id] = bits[9];
`endif
          e = 32'hFFFF_FFFF;
          if (id == 0 && exp_a.size() > 0) e = 32'(exp_a.pop_front());
          if (id != 0 && exp_b.size() > 0) e = 32'(exp_b.pop_front());
          check($sformatf("rx%0d_byte", id), 32'(b8), e);
        end
      end else begin
        check($sformatf("rx%0d_idle_busy", id), 32'(busy_of(id)), 0);
      end
    end
  endtask

  initial rx_run(0);
  initial rx_run(1);

  initial begin
    #300000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int cnt, run, lows;
    bus_a.save_n = '1;
    bus_a.data_input = '0;
    bus_b.save_n = '1;
    bus_b.data_input = '0;
    mvalid[0] = '0;
    mvalid[1] = '0;
    last_par[0] = 1'b0;
    last_par[1] = 1'b0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_txd", 32'(bus_a.uart_txd), 1);
    check("rst_a_busy", 32'(bus_a.uart_tx_busy), 0);
    check("rst_a_sum", 32'(bus_a.sum_out), 0);
    check("rst_a_opv", 32'(bus_a.op_valid), 0);
    check("rst_b_txd", 32'(bus_b.uart_txd), 1);
    check("rst_b_sum", 32'(bus_b.sum_out), 0);
    check("rst_b_opv", 32'(bus_b.op_valid), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    lows = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus_a.uart_txd !== 1'b1 || bus_b.uart_txd !== 1'b1) lows++;
    end
    check("idle50_txd_low_cycles", 32'(lows), 0);

    // 0x5 + 0xA, with capture latency on slot 0
    @(posedge clk); #1;
    bus_a.data_input = 4'h5;
    bus_a.save_n[0] = 1'b0;
    model_commit(0, 8'h01, 12'h5);
    repeat (3) @(negedge clk);
    check("lat_opv_edge2", 32'(bus_a.op_valid), 0);
    @(negedge clk);
    check("lat_opv_edge3", 32'(bus_a.op_valid), 1);
    @(posedge clk); #1 bus_a.save_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    fork
      save(0, 8'h02, 12'hA, 4);
      begin
        wait_busy(0, 1'b1, 40, ok);
        check("t2_launch", 32'(ok), 1);
        cnt = 0;
        for (int k = 0; k < FRAME_CLK; k++) begin
          check($sformatf("t2_txd_clk%0d", k), 32'(bus_a.uart_txd), 32'(PAT0F[k / CDIV]));
          if (bus_a.uart_tx_busy === 1'b1) cnt++;
          @(negedge clk);
        end
        check("t2_busy_cycles", 32'(cnt), FRAME_CLK);
        check("t2_busy_fall", 32'(bus_a.uart_tx_busy), 0);
        check("t2_sum", 32'(bus_a.sum_out), 32'h0F);
        check("t2_opv", 32'(bus_a.op_valid), 0);
      end
    join
    wait_busy(0, 1'b0, 200, ok);
    check("t2_idle", 32'(ok), 1);

    // 0xF + 0xF, slots refilled with 0x1/0x2 while it is on the line
    save(0, 8'h01, 12'hF, 4);
    fork
      begin
        save(0, 8'h02, 12'hF, 4);
        repeat (10) @(posedge clk);
        check("t3_sum", 32'(bus_a.sum_out), 32'h1E);
        save(0, 8'h01, 12'h1, 4);
        save(0, 8'h02, 12'h2, 4);
      end
      begin
        wait_busy(0, 1'b1, 40, ok);
        check("t3_launch", 32'(ok), 1);
        busy_run(0, run);
        check("t4_busy_run", 32'(run), 2 * FRAME_CLK);
      end
    join
    check("t4_sum", 32'(bus_a.sum_out), 32'h03);

    // Held strobe captures once; 0x3 + 0x4 = 0x07
    fork
      save(0, 8'h01, 12'h3, 30);
      begin
        repeat (8) @(posedge clk);
        save(0, 8'h02, 12'h4, 4);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("hold_opv_after_launch", 32'(bus_a.op_valid), 0);
        check("hold_sum", 32'(bus_a.sum_out), 32'h07);
      end
    join
    wait_busy(0, 1'b0, 200, ok);
    check("hold_idle", 32'(ok), 1);
    check("hold_no_recapture", 32'(bus_a.op_valid), 0);
`ifdef SUMLATCH_UART_PARITY_EN
    check("par_sum07", 32'(last_par[0]), 1);
`endif

    // 8 x 0xFFF via simultaneous strobes -> 0x7FF8 as 0xF8, 0x7F
    fork
      save(1, 8'hFF, 12'hFFF, 4);
      begin
        wait_busy(1, 1'b1, 40, ok);
        check("b_launch", 32'(ok), 1);
        busy_run(1, run);
        check("b_busy_run", 32'(run), 2 * FRAME_CLK);
      end
    join
    check("b_sum", 32'(bus_b.sum_out), 32'h7FF8);
    check("b_opv", 32'(bus_b.op_valid), 0);
    repeat (3) @(negedge clk);
    check("a_exp_drained", 32'(exp_a.size()), 0);
    check("b_exp_drained", 32'(exp_b.size()), 0);

    // Reset in the middle of DATA
    save(0, 8'h01, 12'h3, 4);
    fork
      save(0, 8'h02, 12'h3, 4);
      begin
        wait_busy(0, 1'b1, 40, ok);
        check("t5_launch", 32'(ok), 1);
        repeat (13) @(negedge clk);
      end
    join
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_txd", 32'(bus_a.uart_txd), 1);
    check("t5_busy", 32'(bus_a.uart_tx_busy), 0);
    check("t5_opv", 32'(bus_a.op_valid), 0);
    check("t5_sum", 32'(bus_a.sum_out), 0);
    mvalid[0] = '0;
    mvalid[1] = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    lows = 0;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus_a.uart_txd !== 1'b1) lows++;
      if (bus_a.uart_tx_busy !== 1'b0) cnt++;
    end
    check("t5_residual_txd_low", 32'(lows), 0);
    check("t5_residual_busy", 32'(cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
